// File: rtl/dct_block_scheduler_if.sv
// dct_block_scheduler_if: row handshakes between line buffers, block scheduler and DCT datapath
interface dct_block_scheduler_if #(
    parameter int DW      = 8,
    parameter int CREDITS = 2
);
    localparam int CW = $clog2(CREDITS + 1);
    logic [7:0][DW-1:0] y_d;
    logic [2:0]         y_cnt;
    logic               y_valid;
    logic               y_hold;
    logic [7:0][DW-1:0] c_d;
    logic [2:0]         c_cnt;
    logic               c_valid;
    logic               c_hold;
    logic [7:0][DW-1:0] q_d;
    logic [2:0]         q_cnt;
    logic [1:0]         q_comp;
    logic               q_valid;
    logic               q_hold;
    logic               blk_done;
    logic               mcu_done;
    logic [CW-1:0]      credits;
    logic               err;
    modport slave (
        input  y_d, y_cnt, y_valid, c_d, c_cnt, c_valid, q_hold, blk_done,
        output y_hold, c_hold, q_d, q_cnt, q_comp, q_valid, mcu_done, credits, err
    );
    modport master (
        output y_d, y_cnt, y_valid, c_d, c_cnt, c_valid, q_hold, blk_done,
        input  y_hold, c_hold, q_d, q_cnt, q_comp, q_valid, mcu_done, credits, err
    );
endinterface

// File: rtl/dct_block_scheduler.sv
// dct_block_scheduler: credit-metered Y/Cb/Cr block sequencer feeding the shared DCT datapath
module dct_block_scheduler #(
    parameter int DW        = 8,
    parameter int Y_PER_MCU = 4,
    parameter int CREDITS   = 2
) (
    input logic clk,
    input logic resetn,
    dct_block_scheduler_if.slave bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int SW = $clog2(Y_PER_MCU + 2);
    localparam logic [SW-1:0] SEQ_CB = SW'(Y_PER_MCU);
    localparam logic [SW-1:0] SEQ_CR = SW'(Y_PER_MCU + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic {GRANT, XFER} state_t;

    state_t             state, state_nx;
    logic [SW-1:0]      seq;
    logic [2:0]         row;
    logic [CW-1:0]      credits;
    logic               sel_y, xfer, out_busy, grant, acc, last;
    logic [7:0][DW-1:0] src_d;
    logic [2:0]         src_cnt;
    logic [1:0]         comp;

    assign sel_y    = seq < SEQ_CB;
    assign comp     = sel_y ? 2'd0 : (seq == SEQ_CB ? 2'd1 : 2'd2);
    assign src_d    = sel_y ? bus.y_d : bus.c_d;
    assign src_cnt  = sel_y ? bus.y_cnt : bus.c_cnt;
    assign out_busy = bus.q_valid & bus.q_hold;
    assign xfer     = resetn & (state == XFER);
    assign grant    = resetn & (state == GRANT) & (credits != '0);
    assign acc      = xfer & ~out_busy & (sel_y ? bus.y_valid : bus.c_valid);
    assign last     = acc & (row == 3'd7);
    assign bus.mcu_done = last & (seq == SEQ_CR);
    assign bus.credits  = credits;

    // Next state and source stalls; holds stay high in reset and outside a granted block
    always_comb begin
        state_nx   = state;
        bus.y_hold = 1'b1;
        bus.c_hold = 1'b1;
        if (resetn) begin
            state_nx   = state == GRANT ? (grant ? XFER : GRANT) : (last ? GRANT : XFER);
            bus.y_hold = ~(xfer & sel_y) | out_busy;
            bus.c_hold = ~(xfer & ~sel_y) | out_busy;
        end
    end

    // FSM state, MCU sequence, row counter, credit pool and sticky protocol error
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= GRANT;
            seq     <= '0;
            row     <= '0;
            credits <= CRED_MAX;
            bus.err <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) row <= '0;
            else if (acc) row <= row + 3'd1;
            if (last) seq <= seq == SEQ_CR ? '0 : seq + 1'b1;
            credits <= credits - CW'(grant) + CW'(bus.blk_done & ((credits != CRED_MAX) | grant));
            if ((acc && src_cnt != row) || (bus.blk_done && credits == CRED_MAX && !grant))
                bus.err <= 1'b1;
        end
    end

    // Single output register: loads on every accepted row, empties when drained
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.q_valid <= 1'b0;
            bus.q_d     <= '0;
            bus.q_cnt   <= '0;
            bus.q_comp  <= '0;
        end else if (acc) begin
            bus.q_valid <= 1'b1;
            bus.q_d     <= src_d;
            bus.q_cnt   <= src_cnt;
            bus.q_comp  <= comp;
        end else if (!bus.q_hold) begin
            bus.q_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dct_block_scheduler.sv
// tb_dct_block_scheduler: directed vectors and scoreboarded sequences for the block scheduler
module tb_dct_block_scheduler;
    localparam int DW = 8;
    localparam int YP = 4;
    localparam int CR = 2;

    typedef struct {
        logic       rn;
        logic       yv;
        logic [2:0] yc;
        logic       bd;
        logic       yh;
        logic [1:0] cr;
        logic       er;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [2:0]  cnt;
        logic [1:0]  comp;
    } rec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    dct_block_scheduler_if #(.DW(DW), .CREDITS(CR)) dif ();
    dct_block_scheduler #(.DW(DW), .Y_PER_MCU(YP), .CREDITS(CR)) dut (
        .clk(clk), .resetn(resetn), .bus(dif.slave)
    );

    int checks = 0, errors = 0;
    int y_row, c_row, c_blk, ydat, cdat, sink_row, sink_blk, rows_out, mcu_seen, bd_timer;
    bit rn = 0, auto_bd = 1, bd_pulse = 0, hold_q = 0, bad_armed = 0;
    rec_t exp_q[$];
    vec_t tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0][DW-1:0] row_data(input int n, input int base);
        logic [7:0][DW-1:0] r;
        for (int k = 0; k < 8; k++) r[k] = DW'(base + n * 8 + k);
        return r;
    endfunction

    function automatic logic [1:0] sched(input int b);
        return b < YP ? 2'd0 : (b == YP ? 2'd1 : 2'd2);
    endfunction

    function automatic vec_t mk(input int r, input int yv, input int yc, input int bd,
                                input int yh, input int cr, input int er);
        vec_t v;
        v.rn = r[0]; v.yv = yv[0]; v.yc = yc[2:0]; v.bd = bd[0];
        v.yh = yh[0]; v.cr = cr[1:0]; v.er = er[0];
        return v;
    endfunction

    task automatic clear_model();
        y_row = 0; c_row = 0; c_blk = 0; sink_row = 0; sink_blk = 0;
        rows_out = 0; mcu_seen = 0; bd_timer = 0;
        exp_q.delete();
    endtask

    // one clock: drive at negedge, observe handshakes, advance the source/sink models
    task automatic tick();
        logic ya, ca;
        rec_t e;
        @(negedge clk);
        resetn = rn;
        dif.blk_done = bd_pulse;
        if (bd_timer > 0) begin
            bd_timer--;
            if (bd_timer == 0) dif.blk_done = 1'b1;
        end
        dif.q_hold  = hold_q;
        dif.y_valid = 1'b1;
        dif.y_cnt   = (bad_armed && y_row == 2) ? 3'd5 : 3'(y_row);
        dif.y_d     = row_data(ydat, 0);
        dif.c_valid = 1'b1;
        dif.c_cnt   = 3'(c_row);
        dif.c_d     = row_data(cdat, 128);
        #1;
        ya = dif.y_valid & ~dif.y_hold;
        ca = dif.c_valid & ~dif.c_hold;
        if (rn) begin
            check("one_source", 64'(ya & ca), 64'd0);
            check("mcu_done", 64'(dif.mcu_done), 64'(ca && c_blk == 1 && c_row == 7));
            if (dif.mcu_done) mcu_seen++;
            if (ya) begin
                exp_q.push_back('{d: dif.y_d, cnt: dif.y_cnt, comp: 2'd0});
                if (bad_armed && y_row == 2) bad_armed = 0;
                y_row = (y_row + 1) % 8;
                ydat++;
            end
            if (ca) begin
                exp_q.push_back('{d: dif.c_d, cnt: dif.c_cnt, comp: 2'(1 + c_blk)});
                if (c_row == 7) c_blk ^= 1;
                c_row = (c_row + 1) % 8;
                cdat++;
            end
            if (dif.q_valid && !dif.q_hold) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_row", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("q_d", dif.q_d, e.d);
                    check("q_cnt", 64'(dif.q_cnt), 64'(e.cnt));
                    check("q_comp_src", 64'(dif.q_comp), 64'(e.comp));
                    check("q_comp_order", 64'(dif.q_comp), 64'(sched(sink_blk)));
                end
                rows_out++;
                sink_row++;
                if (sink_row == 8) begin
                    sink_row = 0;
                    sink_blk = (sink_blk + 1) % 6;
                    if (auto_bd) bd_timer = 3;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rn = 0;
        tick();
        tick();
        clear_model();
        rn = 1;
    endtask

    initial begin
        logic [63:0] qd;
        dif.y_d = '0; dif.y_cnt = '0; dif.y_valid = 1'b0;
        dif.c_d = '0; dif.c_cnt = '0; dif.c_valid = 1'b0;
        dif.q_hold = 1'b0; dif.blk_done = 1'b0;
        ydat = 0; cdat = 0;
        clear_model();

        tbl[0] = mk(0, 0, 0, 0, 1, 2, 0);
        tbl[1] = mk(1, 0, 0, 0, 1, 1, 0);
        tbl[2] = mk(1, 0, 0, 1, 0, 2, 0);
        tbl[3] = mk(1, 0, 0, 1, 0, 2, 1);
        tbl[4] = mk(1, 0, 0, 0, 0, 2, 1);
        tbl[5] = mk(0, 0, 0, 0, 1, 2, 0);
        tbl[6] = mk(1, 1, 0, 0, 1, 1, 0);
        for (int k = 0; k < 8; k++) tbl[7 + k] = mk(1, 1, k, 0, 0, 1, 0);
        tbl[15] = mk(1, 0, 0, 1, 1, 1, 0);
        tbl[16] = mk(1, 0, 0, 0, 0, 1, 0);

        // reset state
        do_reset();
        check("rst_q_valid", 64'(dif.q_valid), 64'd0);
        check("rst_q_d", dif.q_d, 64'd0);
        check("rst_credits", 64'(dif.credits), 64'(CR));
        check("rst_err", 64'(dif.err), 64'd0);

        // steady 4:2:0 stream, two MCUs
        for (int i = 0; i < 400 && rows_out < 96; i++) tick();
        check("stream_rows", 64'(rows_out), 64'd96);
        check("stream_mcu", 64'(mcu_seen), 64'd2);
        check("stream_err", 64'(dif.err), 64'd0);

        // credit starvation and single release
        auto_bd = 0;
        do_reset();
        for (int i = 0; i < 40; i++) tick();
        check("starve_rows", 64'(rows_out), 64'd16);
        check("starve_credits", 64'(dif.credits), 64'd0);
        check("starve_y_hold", 64'(dif.y_hold), 64'd1);
        bd_pulse = 1;
        tick();
        bd_pulse = 0;
        for (int i = 0; i < 30; i++) tick();
        check("release_rows", 64'(rows_out), 64'd24);
        check("release_credits", 64'(dif.credits), 64'd0);
        auto_bd = 1;

        // downstream stall at row 3
        do_reset();
        for (int i = 0; i < 30 && !(dif.q_valid && dif.q_cnt == 3'd3); i++) tick();
        check("stall_reach", 64'(dif.q_valid && dif.q_cnt == 3'd3), 64'd1);
        qd = dif.q_d;
        hold_q = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_q_cnt", 64'(dif.q_cnt), 64'd3);
            check("stall_q_d", dif.q_d, qd);
            check("stall_y_hold", 64'(dif.y_hold), 64'd1);
        end
        hold_q = 0;
        tick();
        check("stall_next_row", 64'(dif.q_cnt), 64'd4);
        check("stall_next_valid", 64'(dif.q_valid), 64'd1);

        // wrong row index from luma source
        do_reset();
        bad_armed = 1;
        for (int i = 0; i < 30 && bad_armed; i++) tick();
        check("bad_cnt_err", 64'(dif.err), 64'd1);
        for (int i = 0; i < 60 && rows_out < 16; i++) tick();
        check("bad_cnt_rows", 64'(rows_out), 64'd16);
        check("bad_cnt_sticky", 64'(dif.err), 64'd1);

        // cycle vectors: spurious credit return, then return coincident with grant
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            resetn = tbl[i].rn;
            dif.y_valid = tbl[i].yv;
            dif.y_cnt = tbl[i].yc;
            dif.blk_done = tbl[i].bd;
            dif.c_valid = 1'b0;
            dif.q_hold = 1'b0;
            #1;
            check($sformatf("vec%0d_y_hold", i), 64'(dif.y_hold), 64'(tbl[i].yh));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_credits", i), 64'(dif.credits), 64'(tbl[i].cr));
            check($sformatf("vec%0d_err", i), 64'(dif.err), 64'(tbl[i].er));
        end

        // reset during row 4 of the Cb block
        do_reset();
        for (int i = 0; i < 100 && !(c_blk == 0 && c_row == 4); i++) tick();
        check("mid_reach", 64'(c_blk == 0 && c_row == 4), 64'd1);
        rn = 0;
        tick();
        check("mid_q_valid", 64'(dif.q_valid), 64'd0);
        check("mid_credits", 64'(dif.credits), 64'(CR));
        check("mid_y_hold", 64'(dif.y_hold), 64'd1);
        check("mid_c_hold", 64'(dif.c_hold), 64'd1);
        clear_model();
        rn = 1;
        for (int i = 0; i < 20 && !dif.q_valid; i++) tick();
        check("mid_after_valid", 64'(dif.q_valid), 64'd1);
        check("mid_after_comp", 64'(dif.q_comp), 64'd0);
        check("mid_after_cnt", 64'(dif.q_cnt), 64'd0);
        for (int i = 0; i < 20; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
